// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point radix-2 FFT slice: sizes, framer FSM states, sample type
// and the Q8.8 twiddle table used by the core.
package fft_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned N_POINTS    = 8;
  localparam int unsigned FFT_LATENCY = 5;

  // W8^k = exp(-j*2*pi*k/8) in Q8.8, k = 0..3
  localparam logic signed [DATA_W-1:0] TWIDDLE_RE [4] = '{16'sd256, 16'sd181, 16'sd0, -16'sd181};
  localparam logic signed [DATA_W-1:0] TWIDDLE_IM [4] = '{16'sd0, -16'sd181, -16'sd256, -16'sd181};

  typedef enum logic [1:0] {StFill, StLoad, StStart, StWait} state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } sample_t;

endpackage

// File: rtl/fft_frame_buf.sv
// N_POINTS-entry complex sample store: a staging file filled by index and an output file that
// takes a snapshot on commit, so the flat read-out buses only change when a frame is handed over.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = fft_pkg::N_POINTS,
  parameter int unsigned DATA_W   = fft_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(N_POINTS)-1:0]  widx,
  input  logic [DATA_W-1:0]            wreal,
  input  logic [DATA_W-1:0]            wimag,
  input  logic                         commit,
  output logic [N_POINTS*DATA_W-1:0]   frame_real,
  output logic [N_POINTS*DATA_W-1:0]   frame_imag
);

  localparam int unsigned IdxW = $clog2(N_POINTS);

  logic [DATA_W-1:0] stage_re_q [N_POINTS];
  logic [DATA_W-1:0] stage_im_q [N_POINTS];
  logic [DATA_W-1:0] out_re_q   [N_POINTS];
  logic [DATA_W-1:0] out_im_q   [N_POINTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_POINTS; k++) begin
        stage_re_q[k] <= '0;
        stage_im_q[k] <= '0;
        out_re_q[k]   <= '0;
        out_im_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_POINTS; k++) begin
        if (we && (widx == IdxW'(k))) begin
          stage_re_q[k] <= wreal;
          stage_im_q[k] <= wimag;
        end
        // A commit may coincide with the final write; merge it so the snapshot is complete.
        if (commit) begin
          out_re_q[k] <= (we && (widx == IdxW'(k))) ? wreal : stage_re_q[k];
          out_im_q[k] <= (we && (widx == IdxW'(k))) ? wimag : stage_im_q[k];
        end
      end
    end
  end

  for (genvar k = 0; k < N_POINTS; k++) begin : g_flat
    assign frame_real[k*DATA_W +: DATA_W] = out_re_q[k];
    assign frame_imag[k*DATA_W +: DATA_W] = out_im_q[k];
  end

endmodule

// File: rtl/fft_input_framer.sv
// Streams complex samples into N_POINTS frames and hands them to the FFT core via write/start.
// Define FFT_INPUT_FRAMER_PINGPONG_EN for double buffering so input keeps flowing while busy.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS    = fft_pkg::N_POINTS,
  parameter int unsigned DATA_W      = fft_pkg::DATA_W,
  parameter int unsigned FFT_LATENCY = fft_pkg::FFT_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_real,
  input  logic [DATA_W-1:0]           s_imag,
  input  logic                        s_last,
  output logic [N_POINTS*DATA_W-1:0]  frame_real,
  output logic [N_POINTS*DATA_W-1:0]  frame_imag,
  output logic                        write,
  output logic                        start,
  output logic                        busy,
  output logic                        frame_err,
  output logic [15:0]                 frame_cnt
);

  localparam int unsigned IdxW  = $clog2(N_POINTS);
  localparam int unsigned WaitW = $clog2(FFT_LATENCY + 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  logic beat, at_end, done, early;

  assign beat   = s_valid && s_ready;
  assign at_end = (idx_q == IdxW'(N_POINTS - 1));
  assign done   = beat && at_end;
  assign early  = beat && s_last && !at_end;

`ifdef FFT_INPUT_FRAMER_PINGPONG_EN
  logic                       fill_sel_q, fill_sel_d;
  logic                       disp_sel_q, disp_sel_d;
  logic                       pend_q, pend_d;
  logic                       pend_err_q, pend_err_d;
  logic                       core_free;
  logic [1:0]                 commit;
  logic [N_POINTS*DATA_W-1:0] buf_real [2];
  logic [N_POINTS*DATA_W-1:0] buf_imag [2];

  for (genvar b = 0; b < 2; b++) begin : g_buf
    fft_frame_buf #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W)
    ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .we         (beat && (fill_sel_q == 1'(b))),
      .widx       (idx_q),
      .wreal      (s_real),
      .wimag      (s_imag),
      .commit     (commit[b]),
      .frame_real (buf_real[b]),
      .frame_imag (buf_imag[b])
    );
  end

  assign frame_real = buf_real[disp_sel_q];
  assign frame_imag = buf_imag[disp_sel_q];
  // The core can take a new frame now or in the cycle right after WAIT expires.
  assign core_free  = (state_q == StFill) || ((state_q == StWait) && (wait_q == WaitW'(1)));
  assign s_ready    = !pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_sel_q <= 1'b0;
      disp_sel_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_d;
      disp_sel_q <= disp_sel_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end
`else
  logic commit;

  fft_frame_buf #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .we         (beat),
    .widx       (idx_q),
    .wreal      (s_real),
    .wimag      (s_imag),
    .commit     (commit),
    .frame_real (frame_real),
    .frame_imag (frame_imag)
  );

  assign s_ready = (state_q == StFill);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    err_d   = early;
    if (beat) begin
      idx_d = (at_end || s_last) ? '0 : idx_q + IdxW'(1);
    end

    unique case (state_q)
      StFill:  ;
      StLoad:  state_d = StStart;
      StStart: begin
        state_d = StWait;
        wait_d  = WaitW'(FFT_LATENCY);
      end
      StWait: begin
        wait_d = wait_q - WaitW'(1);
        if (wait_q == WaitW'(1)) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

`ifdef FFT_INPUT_FRAMER_PINGPONG_EN
    fill_sel_d = fill_sel_q;
    disp_sel_d = disp_sel_q;
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
    commit     = 2'b00;
    if (pend_q && core_free) begin
      // Held frame sits in the buffer not currently selected for filling.
      state_d    = StLoad;
      commit     = fill_sel_q ? 2'b01 : 2'b10;
      disp_sel_d = !fill_sel_q;
      pend_d     = 1'b0;
      cnt_d      = cnt_q + 16'd1;
      err_d      = early || pend_err_q;
    end else if (done) begin
      fill_sel_d = !fill_sel_q;
      if (core_free) begin
        state_d    = StLoad;
        commit     = fill_sel_q ? 2'b10 : 2'b01;
        disp_sel_d = fill_sel_q;
        cnt_d      = cnt_q + 16'd1;
        err_d      = !s_last;
      end else begin
        pend_d     = 1'b1;
        pend_err_d = !s_last;
      end
    end
`else
    commit = 1'b0;
    if (done) begin
      state_d = StLoad;
      commit  = 1'b1;
      cnt_d   = cnt_q + 16'd1;
      err_d   = !s_last;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      idx_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign write     = (state_q == StLoad);
  assign start     = (state_q == StStart);
  assign busy      = (state_q != StFill);
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer: frame assembly, timing, s_last handling, reset, and
// back-to-back frames when built with FFT_INPUT_FRAMER_PINGPONG_EN.
module tb_fft_input_framer;

  localparam int FW = 8 * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_real = '0;
  logic [15:0]   s_imag = '0;
  logic          s_last = 1'b0;
  logic [FW-1:0] frame_real, frame_imag;
  logic          write, start, busy, frame_err;
  logic [15:0]   frame_cnt;

  fft_input_framer dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_real     (s_real),
    .s_imag     (s_imag),
    .s_last     (s_last),
    .frame_real (frame_real),
    .frame_imag (frame_imag),
    .write      (write),
    .start      (start),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Event monitor, sampled mid-cycle.
  int wr_cnt = 0, st_cnt = 0, err_cnt = 0, co_cnt = 0, nrdy = 0, busy_cnt = 0;
  int last_wr_cyc = 0, last_st_cyc = 0;
  int wr_cyc_q [$];
  logic [FW-1:0] cap_re [$];
  logic [FW-1:0] cap_im [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (!s_ready) nrdy++;
      if (busy) busy_cnt++;
      if (write) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
        cap_re.push_back(frame_real);
        cap_im.push_back(frame_imag);
      end
      if (start) begin
        st_cnt++;
        last_st_cyc = cyc;
      end
      if (frame_err) err_cnt++;
      if (write && frame_err) co_cnt++;
    end
  end

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] rv(input int i);
    return (i < 8) ? 16'(i * 256) : 16'(i * 259);
  endfunction

  function automatic logic [15:0] iv(input int i);
    return (i < 8) ? 16'(-(i * 256)) : 16'(i * 71 - 3000);
  endfunction

  function automatic logic [FW-1:0] exp_re(input int base);
    logic [FW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = rv(base + k);
    return v;
  endfunction

  function automatic logic [FW-1:0] exp_im(input int base);
    logic [FW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = iv(base + k);
    return v;
  endfunction

  int last_beat = 0;

  // Sends n samples base..base+n-1; s_last where (i % 8) == lastpos, none if lastpos < 0.
  task automatic send(input int base, input int n, input int lastpos);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      s_valid = 1'b1;
      s_real  = rv(base + i);
      s_imag  = iv(base + i);
      s_last  = (lastpos >= 0) && ((i % 8) == lastpos);
      if (s_ready) begin
        last_beat = cyc;
        i++;
      end
      tick();
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("send_beats", i, n);
  endtask

  task automatic wait_write(input int target);
    int g;
    g = 0;
    while (wr_cnt < target && g < 60) begin
      tick();
      g++;
    end
    check("write_seen", wr_cnt, target);
  endtask

  int e0, w0, s0, c0, n0, b0;

  initial begin
    rst = 1'b1;
    tick(2);
    check("rst_real", frame_real, '0);
    check("rst_imag", frame_imag, '0);
    check("rst_cnt", frame_cnt, 16'd0);
    check("rst_ready", s_ready, 1'b1);
    check("rst_pulses", {write, start, busy, frame_err}, 4'b0000);
    rst = 1'b0;
    tick();

`ifdef FFT_INPUT_FRAMER_PINGPONG_EN
    n0 = nrdy;
    send(100, 32, 7);
    wait_write(4);
    tick(12);
    check("pp_nready", nrdy - n0, 0);
    for (int j = 1; j < 4; j++) check("pp_period", wr_cyc_q[j] - wr_cyc_q[j-1], 8);
    for (int j = 0; j < 4; j++) begin
      check("pp_real", cap_re[j], exp_re(100 + 8 * j));
      check("pp_imag", cap_im[j], exp_im(100 + 8 * j));
    end
    check("pp_bus_hold", frame_real, exp_re(124));
    check("pp_cnt", frame_cnt, 16'd4);
`else
    // 1: single frame, timing and data
    e0 = err_cnt; n0 = nrdy; b0 = busy_cnt;
    send(0, 8, 7);
    wait_write(1);
    tick(2);
    check("t1_write_lat", last_wr_cyc - last_beat, 1);
    check("t1_start_lat", last_st_cyc - last_beat, 2);
    check("t1_real", cap_re[0], exp_re(0));
    check("t1_imag", cap_im[0], exp_im(0));
    tick(10);
    check("t1_cnt", frame_cnt, 16'd1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_nready", nrdy - n0, 7);
    check("t1_busy", busy_cnt - b0, 7);
    check("t1_ready", s_ready, 1'b1);

    // 2: s_valid held high across two frames
    n0 = nrdy;
    send(8, 16, 7);
    wait_write(3);
    tick(10);
    check("t2_f1_real", cap_re[1], exp_re(8));
    check("t2_f2_real", cap_re[2], exp_re(16));
    check("t2_f2_imag", cap_im[2], exp_im(16));
    check("t2_nready", nrdy - n0, 14);
    check("t2_cnt", frame_cnt, 16'd3);

    // 3: early s_last at index 2, then a clean frame
    e0 = err_cnt; w0 = wr_cnt;
    send(24, 3, 2);
    tick(3);
    check("t3_err", err_cnt - e0, 1);
    check("t3_nowrite", wr_cnt - w0, 0);
    check("t3_bus_kept", frame_real, exp_re(16));
    send(27, 8, 7);
    wait_write(w0 + 1);
    tick(10);
    check("t3_real", cap_re[3], exp_re(27));
    check("t3_imag", cap_im[3], exp_im(27));
    check("t3_cnt", frame_cnt, 16'd4);
    check("t3_err_once", err_cnt - e0, 1);

    // 4: missing s_last
    e0 = err_cnt; c0 = co_cnt;
    send(35, 8, -1);
    wait_write(5);
    tick(10);
    check("t4_coincident", co_cnt - c0, 1);
    check("t4_err", err_cnt - e0, 1);
    check("t4_cnt", frame_cnt, 16'd5);
    check("t4_real", cap_re[4], exp_re(35));
    check("t4_imag", cap_im[4], exp_im(35));

    // 5: reset mid-frame
    w0 = wr_cnt; s0 = st_cnt;
    send(43, 5, -1);
    rst = 1'b1;
    tick();
    check("t5_real", frame_real, '0);
    check("t5_imag", frame_imag, '0);
    check("t5_cnt", frame_cnt, 16'd0);
    check("t5_ready", s_ready, 1'b1);
    rst = 1'b0;
    tick(10);
    check("t5_nowrite", wr_cnt - w0, 0);
    check("t5_nostart", st_cnt - s0, 0);
    send(48, 8, 7);
    wait_write(w0 + 1);
    tick(10);
    check("t5_real2", cap_re[5], exp_re(48));
    check("t5_imag2", cap_im[5], exp_im(48));
    check("t5_cnt2", frame_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_input_framer.md
Name: fft_input_framer

Overview:
Upstream neighbour of the 8-point radix-2 FFT core. Accepts complex samples one per beat over a valid/ready stream and assembles them into an N-point frame. Presents the frame as flat parallel buses, then pulses `write` and, one cycle later, `start` to the core. Holds off the next frame until the core's fixed processing latency has elapsed.

Parameters:
- N_POINTS, 8, samples per frame; power of two, min 2.
- DATA_W, 16, signed Q8.8 width of each real and imag component.
- FFT_LATENCY, 5, cycles the core needs after `start` before a new frame may be written; min 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  framer can accept a sample
- s_real  in  DATA_W  sample real part, signed
- s_imag  in  DATA_W  sample imag part, signed
- s_last  in  1  marks the final sample of a frame
- frame_real  out  N_POINTS*DATA_W  real parts, natural order; sample k at [k*DATA_W +: DATA_W]
- frame_imag  out  N_POINTS*DATA_W  imag parts, same packing
- write  out  1  one-cycle pulse: frame buses valid, core captures them
- start  out  1  one-cycle pulse, the cycle after `write`
- busy  out  1  high in LOAD, START and WAIT
- frame_err  out  1  one-cycle pulse on an s_last misalignment
- frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- Reset, in the same cycle `rst` is sampled high:
  - state = FILL, sample index = 0, wait counter = 0.
  - all buffer entries = 0, so frame_real and frame_imag are 0.
  - s_ready = 1 from the first cycle after reset; write, start, busy, frame_err = 0; frame_cnt = 0.
- Reset mid-frame discards any partial frame and any pending write or start. No pulses are emitted after reset.
- A beat is a handshake: s_valid && s_ready at the clock edge. The sample is stored at the current index, then the index increments.
- Outputs are registered, so every pulse appears the cycle after its cause.
- Output order is natural (index 0 = first sample). The core performs the bit-reversal.
- FSM:
  - FILL: s_ready = 1. On a beat at index N_POINTS-1 -> LOAD; the index returns to 0.
  - LOAD: write = 1 for exactly one cycle. frame_cnt increments. -> START.
  - START: start = 1 for exactly one cycle. Wait counter loads FFT_LATENCY. -> WAIT.
  - WAIT: counter decrements each cycle. On reaching 0 -> FILL.
  - busy = 1 in LOAD, START and WAIT.
- Timing: last beat at cycle t -> write at t+1, start at t+2, s_ready high again at t+3+FFT_LATENCY.
- Frame buses are stable from the write cycle until the next write. They are never modified while busy.
- s_last rules:
  - s_last on the beat at index N_POINTS-1: normal frame completion.
  - Early s_last (beat at index < N_POINTS-1): the partial frame is dropped and the index returns to 0. frame_err pulses; no write, no frame_cnt change. Buffer contents from the last good frame are kept on the frame buses.
  - Missing s_last on the beat at index N_POINTS-1: the frame completes normally and frame_err pulses in the same cycle as write.
- s_valid while s_ready = 0 is not a beat. The upstream source must hold its data.
- The data path has no arithmetic. Values are passed bit-exact with no saturation.

Optional Feature:
- Macro: FFT_INPUT_FRAMER_PINGPONG_EN.
- Defined:
  - Two frame buffers are used. s_ready stays 1 during LOAD, START and WAIT, and samples fill the alternate buffer.
  - The frame buses always show the buffer last written to the core.
  - If the alternate buffer completes while still in WAIT, it is held. Its write is issued the cycle after WAIT expires, and s_ready = 0 until that write.
  - Throughput is one frame per max(N_POINTS, FFT_LATENCY+2) cycles.
- Undefined: single buffer, exactly as described above.

Decomposition:
- Shared package fft_pkg holds:
  - constants DATA_W = 16, N_POINTS = 8, FFT_LATENCY = 5, and the twiddle constants used by the core;
  - the state enum FILL / LOAD / START / WAIT;
  - the Q8.8 sample typedef.
- One natural sub-module, fft_frame_buf: N_POINTS-entry register file with write index, flat-bus read-out and clear-on-reset. It is instantiated once, or twice when the ping-pong feature is enabled.

Test Plan:
1. Reset, then 8 consecutive beats with s_real = k*256, s_imag = -k*256, s_last on k = 7. Expect:
   - write at t+1 and start at t+2;
   - frame_real slice k = k*256 and frame_imag slice k = -k*256;
   - frame_cnt = 1, frame_err never asserted;
   - s_ready low for exactly 7 cycles.
2. Hold s_valid high continuously across two frames. Expect s_ready = 0 during LOAD/START/WAIT, no samples lost, and the second frame equal to samples 8..15.
3. s_last on the 3rd beat (index 2). Expect:
   - frame_err pulses once, with no write;
   - the next 8 beats form a correct frame, with s_last on the 8th (index 7).
4. 8 beats with no s_last. Expect write and frame_err coincident, frame_cnt incremented, and data intact.
5. Assert rst after 5 beats. Expect:
   - the cycle after rst: frame buses = 0, frame_cnt = 0, s_ready = 1;
   - no write or start pulse;
   - the next full frame is correct.
6. With FFT_INPUT_FRAMER_PINGPONG_EN: back-to-back frames with s_valid always high. Expect write pulses every 8 cycles, s_ready never low, and frame buses alternating between correct frames.
